// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: arbiter FSM states and
// default address/data widths of the external video RAM.
package vram_arbiter_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DISP_RD  = 3'd1,
      ST_DISP_CAP = 3'd2,
      ST_CPU_WR   = 3'd3,
      ST_CPU_RD   = 3'd4,
      ST_CPU_CAP  = 3'd5
   } arb_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares one single-port synchronous RAM between the
// display fetch path (DA/DD, highest priority) and a request/ack CPU port.
// A started CPU access always runs to completion before a display fetch.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_25,
   input  logic              reset,
   input  logic [ADDR_W-1:0] DA,
   output logic [DATA_W-1:0] DD,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [ADDR_W-1:0] da_q;
   logic [ADDR_W-1:0] fetch_q;
   logic              disp_pend_q;
   logic              disp_pend_d;
   logic [DATA_W-1:0] dd_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ack_q;
   logic              da_changed_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic              mem_we_s;
   logic [DATA_W-1:0] mem_wdata_s;

   assign da_changed_s = (DA != da_q);

   // FSM state register
   always_ff @(posedge clk_25) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: display first, no CPU start while the previous ack is out
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (disp_pend_q) begin
               state_d = ST_DISP_RD;
            end else if (cpu_req && !ack_q) begin
               if (cpu_we) begin
                  state_d = ST_CPU_WR;
               end else begin
                  state_d = ST_CPU_RD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DISP_RD:  state_d = ST_DISP_CAP;
         ST_DISP_CAP: state_d = ST_IDLE;
         ST_CPU_WR:   state_d = ST_IDLE;
         ST_CPU_RD:   state_d = ST_CPU_CAP;
         ST_CPU_CAP:  state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: RAM port drive; reset blocks a write still in flight
   always_comb begin
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_we_s    = 1'b0;
      mem_wdata_s = {DATA_W{1'b0}};
      if (reset) begin
         mem_we_s = 1'b0;
      end else begin
         case (state_q)
            ST_DISP_RD: begin
               mem_addr_s = da_q;
            end
            ST_CPU_WR: begin
               mem_addr_s  = cpu_addr;
               mem_wdata_s = cpu_wdata;
               mem_we_s    = 1'b1;
            end
            ST_CPU_RD: begin
               mem_addr_s = cpu_addr;
            end
            default: begin
               mem_addr_s = {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // Display pending flag: set on any DA change; cleared only when the
   // captured fetch matches the current, unchanged display address
   always_comb begin
      if (da_changed_s) begin
         disp_pend_d = 1'b1;
      end else if ((state_q == ST_DISP_CAP) && (fetch_q == da_q)) begin
         disp_pend_d = 1'b0;
      end else begin
         disp_pend_d = disp_pend_q;
      end
   end

   // Display address tracking and fetch bookkeeping
   always_ff @(posedge clk_25) begin
      if (reset) begin
         da_q        <= {ADDR_W{1'b0}};
         fetch_q     <= {ADDR_W{1'b0}};
         disp_pend_q <= 1'b1;
      end else begin
         da_q        <= DA;
         disp_pend_q <= disp_pend_d;
         if (state_q == ST_DISP_RD) begin
            fetch_q <= da_q;
         end else begin
            fetch_q <= fetch_q;
         end
      end
   end

   // Data capture registers and completion pulse
   always_ff @(posedge clk_25) begin
      if (reset) begin
         dd_q    <= {DATA_W{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
         ack_q   <= 1'b0;
      end else begin
         ack_q <= (state_q == ST_CPU_WR) || (state_q == ST_CPU_CAP);
         if (state_q == ST_DISP_CAP) begin
            dd_q <= mem_rdata;
         end else begin
            dd_q <= dd_q;
         end
         if (state_q == ST_CPU_CAP) begin
            rdata_q <= mem_rdata;
         end else begin
            rdata_q <= rdata_q;
         end
      end
   end

   assign DD        = dd_q;
   assign cpu_rdata = rdata_q;
   assign cpu_ack   = ack_q;
   assign mem_addr  = mem_addr_s;
   assign mem_we    = mem_we_s;
   assign mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural synchronous RAM,
// directed scenarios plus randomized CPU traffic against a shadow memory.
module tb_vram_arbiter;

   localparam int AW = 13;
   localparam int DW = 8;

   logic          clk_25 = 1'b0;
   logic          reset;
   logic [AW-1:0] DA;
   logic [DW-1:0] DD;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   int ack_total = 0;
   int we_total = 0;

   logic [DW-1:0] ram [0:8191];
   bit            wr_flag [0:8191];
   logic [DW-1:0] exp_mem [int];

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_25(clk_25), .reset(reset), .DA(DA), .DD(DD),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk_25 = ~clk_25;

   // Power-up content of the video RAM (RAM[5] = 0xA3)
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 13'h0005) return 8'hA3;
      return a[7:0] ^ {a[12:8], 3'b101};
   endfunction

   // Expected RAM content according to the writes the CPU completed
   function automatic logic [DW-1:0] exp_rd(input int a);
      logic [AW-1:0] aa;
      aa = a[AW-1:0];
      if (exp_mem.exists(a)) return exp_mem[a];
      return init_val(aa);
   endfunction

   // External single-port synchronous RAM, one-cycle read latency
   always @(posedge clk_25) begin
      if (mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         wr_flag[mem_addr] <= 1'b1;
      end
      mem_rdata <= wr_flag[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
   end

   // Event counters for ack pulses and write-enable cycles
   always @(posedge clk_25) begin
      if (cpu_ack) ack_total <= ack_total + 1;
      if (mem_we)  we_total  <= we_total + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_25);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One CPU transaction; returns read data and whether ack arrived in time
   task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             output logic [DW-1:0] rd, output logic ok);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      ok = 1'b0; rd = '0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (cpu_ack) begin
            ok = 1'b1;
            rd = cpu_rdata;
            break;
         end
      end
      cpu_req = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          ok;
      int            ack_base, we_base, ack_i, dd_i;
      logic [DW-1:0] old_dd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;

      reset = 1'b1; DA = 13'h0005; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0;
      tick(3);
      check("rst_dd", DD, 0);
      check("rst_ack", cpu_ack, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);

      // First fetch after reset release
      ack_base = ack_total;
      reset = 1'b0;
      tick(6);
      check("boot_dd", DD, 8'hA3);
      check("boot_no_ack", ack_total - ack_base, 0);

      // Write then read back
      ack_base = ack_total; we_base = we_total;
      cpu_access(1'b1, 13'h0123, 8'h5A, rd, ok);
      exp_mem[32'h123] = 8'h5A;
      check("wr_ack", ok, 1);
      tick(3);
      check("wr_we_cycles", we_total - we_base, 1);
      check("wr_ack_pulses", ack_total - ack_base, 1);
      cpu_access(1'b0, 13'h0123, 8'h00, rd, ok);
      check("rd_ack", ok, 1);
      check("rd_data", rd, 8'h5A);
      tick(3);
      check("rd_hold", cpu_rdata, 8'h5A);

      // DA change coincident with a CPU read start
      DA = 13'h0200;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
      ack_i = 0; dd_i = 0;
      for (int i = 1; i <= 12; i++) begin
         tick(1);
         if (cpu_ack && ack_i == 0) begin
            ack_i = i;
            cpu_req = 1'b0;
            check("coinc_rdata", cpu_rdata, 8'h5A);
         end
         if (DD == exp_rd(32'h200) && dd_i == 0) dd_i = i;
      end
      cpu_req = 1'b0;
      check("coinc_ack_seen", (ack_i > 0) ? 1 : 0, 1);
      check("coinc_cpu_first", (ack_i > 0 && ack_i < dd_i) ? 1 : 0, 1);
      check("coinc_dd_latency", (dd_i > 0 && dd_i <= 6) ? 1 : 0, 1);

      // DA change while the first fetch is in its capture cycle
      tick(4);
      DA = 13'h0300;
      tick(3);
      DA = 13'h0301;
      tick(6);
      check("recap_dd", DD, exp_rd(32'h301));

      // CPU write to the displayed address leaves DD alone until refetch
      old_dd = DD;
      cpu_access(1'b1, 13'h0301, 8'hC7, rd, ok);
      exp_mem[32'h301] = 8'hC7;
      check("same_addr_ack", ok, 1);
      tick(8);
      check("same_addr_dd_stale", DD, old_dd);
      DA = 13'h0400; tick(8);
      DA = 13'h0301; tick(8);
      check("same_addr_dd_new", DD, 8'hC7);

      // Reset during the write cycle aborts the write
      ack_base = ack_total; we_base = we_total;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0555; cpu_wdata = 8'h99;
      tick(1);
      reset = 1'b1;
      tick(1);
      check("abort_dd_rst", DD, 0);
      reset = 1'b0; cpu_req = 1'b0;
      tick(6);
      check("abort_no_ack", ack_total - ack_base, 0);
      check("abort_no_we", we_total - we_base, 0);
      check("abort_ram_untouched", wr_flag[13'h0555] ? 1 : 0, 0);
      check("abort_refetch_dd", DD, 8'hC7);

      // Randomized CPU traffic with occasional DA moves
      for (int n = 0; n < 30; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 13'($urandom_range(0, 8191));
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) DA = 13'($urandom_range(0, 8191));
         cpu_access(w, a, d, rd, ok);
         check("rand_ack", ok, 1);
         if (w) begin
            exp_mem[int'(a)] = d;
         end else begin
            check("rand_rdata", rd, exp_rd(int'(a)));
         end
         tick(1);
      end
      DA = 13'h0701; tick(8);
      DA = 13'h0700; tick(8);
      check("rand_final_dd", DD, exp_rd(32'h700));

      // DA sweep with a continuously requesting CPU writer
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1000; cpu_wdata = 8'h11;
      exp_mem[32'h1000] = 8'h11;
      for (int k = 0; k < 256; k++) begin
         DA = 13'(k);
         ack_base = ack_total;
         tick(6);
         check("sweep_dd", DD, exp_rd(k));
         tick(14);
         if (k > 0) check("sweep_cpu_rate", (ack_total - ack_base >= 5) ? 1 : 0, 1);
      end
      cpu_req = 1'b0;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, video RAM address width.
REQ-002 Parameter DATA_W, default 8, video RAM data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_25  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 DA  input  ADDR_W  display fetch address from the video generator.
REQ-007 DD  output  DATA_W  display fetch data returned to the video generator.
REQ-008 cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-009 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-010 cpu_addr  input  ADDR_W  CPU address; held stable while cpu_req is high.
REQ-011 cpu_wdata  input  DATA_W  CPU write data; held stable while cpu_req is high.
REQ-012 cpu_ack  output  1  one-cycle completion pulse.
REQ-013 cpu_rdata  output  DATA_W  read data, valid in the cpu_ack cycle, held until the next CPU read completes.
REQ-014 mem_addr  output  ADDR_W  single-port synchronous RAM address.
REQ-015 mem_we  output  1  RAM write enable.
REQ-016 mem_wdata  output  DATA_W  RAM write data.
REQ-017 mem_rdata  input  DATA_W  RAM read data, one-cycle latency after mem_addr is presented.

Function
REQ-018 DA SHALL be registered every cycle into da_q; disp_pend SHALL set whenever DA != da_q.
REQ-019 FSM states: IDLE, DISP_RD, DISP_CAP, CPU_WR, CPU_RD, CPU_CAP.
REQ-020 IDLE: disp_pend -> DISP_RD; else cpu_req & cpu_we -> CPU_WR; else cpu_req & ~cpu_we -> CPU_RD; else stay.
REQ-021 Display access SHALL have priority over CPU access; a started CPU access SHALL NOT be preempted.
REQ-022 DISP_RD: mem_addr = da_q, mem_we = 0; next state DISP_CAP.
REQ-023 DISP_CAP: DD <= mem_rdata; clear disp_pend unless DA changed in this same cycle, in which case it stays set; next state IDLE.
REQ-024 CPU_WR: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = 1 for exactly one cycle; next state IDLE with cpu_ack = 1 in that IDLE cycle.
REQ-025 CPU_RD: mem_addr = cpu_addr, mem_we = 0; next state CPU_CAP.
REQ-026 CPU_CAP: cpu_rdata <= mem_rdata; next state IDLE with cpu_ack = 1 in that IDLE cycle.
REQ-027 The requester drops cpu_req in the cycle cpu_ack is high; the FSM SHALL NOT start a CPU access in a cycle where cpu_ack is high.
REQ-028 DD SHALL be valid no later than 6 cycles after a DA change, and SHALL be held stable between fetches.
REQ-029 mem_we SHALL be 0 in every state except CPU_WR.
REQ-030 With continuous cpu_req and DA changing every 20 cycles, the CPU SHALL still complete at least 5 accesses per DA period.
REQ-031 A CPU write to the address equal to da_q SHALL NOT refresh DD until the next display fetch.

Reset
REQ-032 On reset: state = IDLE, DD = 0, cpu_rdata = 0, cpu_ack = 0, mem_we = 0, mem_addr = 0, da_q = 0, disp_pend = 1.
REQ-033 Reset mid-access SHALL abort the access with no cpu_ack; a CPU_WR aborted in its cycle SHALL NOT assert mem_we afterwards.
REQ-034 The first action after reset release SHALL be a display fetch of the current DA.

Structure
REQ-035 Package vram_arbiter_pkg SHALL hold the FSM state enum and the ADDR_W/DATA_W defaults.
REQ-036 No sub-module is required; the RAM is external to the block.

Verification
REQ-037 Reset release with DA=0x0005 and RAM[5]=0xA3 -> DD=0xA3 within 6 cycles; cpu_ack stays 0.
REQ-038 cpu_req=1, cpu_we=1, addr 0x0123, wdata 0x5A -> mem_we high exactly 1 cycle; cpu_ack pulses once; a later read of 0x0123 returns 0x5A in cpu_rdata.
REQ-039 DA changes in the same cycle a CPU read starts -> CPU read completes first; DD updates to the new RAM value at most 6 cycles after the DA change.
REQ-040 DA changes during DISP_CAP -> a second display fetch follows immediately and DD ends with data from the newest DA.
REQ-041 Reset asserted in the CPU_WR cycle -> no cpu_ack; RAM content unchanged after that cycle; next access is a display fetch.
REQ-042 DA stepping 0x0000..0x00FF every 20 cycles with cpu_req held high -> no missed DD update; at least 5 cpu_ack pulses per DA step.
